// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding and fetch stride.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    FULL  = 2'b10,
    FLUSH = 2'b11
  } fetch_state_e;

  localparam int unsigned INST_STRIDE = 4;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: requests instructions from memory, fills the IF/ID entry,
// absorbs one response in a skid buffer under back-pressure, and handles PC redirects.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned     ADDR_WIDTH = 17,
  parameter int unsigned     LEN        = 32,
  parameter logic [LEN-1:0]  RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy_in,
  output logic                  inst_fetch_enabled,
  output logic [ADDR_WIDTH-1:0] mem_inst_addr,
  input  logic                  inst_valid,
  input  logic [LEN-1:0]        instruction,
  input  logic                  id_ready,
  input  logic                  branch_taken,
  input  logic [LEN-1:0]        branch_target,
  output logic                  if_id_valid,
  output logic [LEN-1:0]        if_id_inst,
  output logic [LEN-1:0]        if_id_pc
);

  localparam logic [LEN-1:0] STRIDE     = LEN'(INST_STRIDE);
  localparam logic [LEN-1:0] ALIGN_MASK = ~(LEN'(3));

  fetch_state_e          state_r, state_s;
  logic [LEN-1:0]        pc_r, pc_s;
  logic                  if_id_valid_r, if_id_valid_s;
  logic [LEN-1:0]        if_id_inst_r, if_id_inst_s;
  logic [LEN-1:0]        if_id_pc_r, if_id_pc_s;
  logic                  skid_valid_r, skid_valid_s;
  logic [LEN-1:0]        skid_inst_r, skid_inst_s;
  logic [LEN-1:0]        skid_pc_r, skid_pc_s;
  logic                  fetch_en_r, fetch_en_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_s;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    if_id_valid_s = if_id_valid_r;
    if_id_inst_s  = if_id_inst_r;
    if_id_pc_s    = if_id_pc_r;
    skid_valid_s  = skid_valid_r;
    skid_inst_s   = skid_inst_r;
    skid_pc_s     = skid_pc_r;
    fetch_en_s    = fetch_en_r;
    addr_s        = addr_r;

    if (!rdy_in) begin
      state_s = state_r;
    end else if (branch_taken) begin
      // Redirect wins over everything; a still-outstanding request forces FLUSH
      pc_s          = branch_target & ALIGN_MASK;
      if_id_valid_s = 1'b0;
      skid_valid_s  = 1'b0;
      case (state_r)
        IDLE:    state_s = FETCH;
        FETCH:   state_s = inst_valid ? FETCH : FLUSH;
        FULL:    state_s = FETCH;
        FLUSH:   state_s = inst_valid ? FETCH : FLUSH;
        default: state_s = IDLE;
      endcase
    end else begin
      if (id_ready) begin
        if_id_valid_s = 1'b0;
      end else begin
        if_id_valid_s = if_id_valid_r;
      end
      case (state_r)
        IDLE: begin
          state_s = FETCH;
        end
        FETCH: begin
          if (inst_valid) begin
            pc_s = pc_r + STRIDE;
            if (!if_id_valid_r || id_ready) begin
              if_id_valid_s = 1'b1;
              if_id_inst_s  = instruction;
              if_id_pc_s    = pc_r;
              state_s       = FETCH;
            end else begin
              skid_valid_s  = 1'b1;
              skid_inst_s   = instruction;
              skid_pc_s     = pc_r;
              state_s       = FULL;
            end
          end else begin
            state_s = FETCH;
          end
        end
        FULL: begin
          if (id_ready) begin
            if_id_valid_s = 1'b1;
            if_id_inst_s  = skid_inst_r;
            if_id_pc_s    = skid_pc_r;
            skid_valid_s  = 1'b0;
            state_s       = FETCH;
          end else begin
            state_s = FULL;
          end
        end
        FLUSH: begin
          state_s = inst_valid ? FETCH : FLUSH;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end

    // FLUSH keeps presenting the address of the request being drained
    case (state_s)
      FETCH: begin
        fetch_en_s = 1'b1;
        addr_s     = pc_s[ADDR_WIDTH-1:0];
      end
      FLUSH: begin
        fetch_en_s = 1'b1;
        addr_s     = addr_r;
      end
      default: begin
        fetch_en_s = 1'b0;
        addr_s     = pc_s[ADDR_WIDTH-1:0];
      end
    endcase
  end

  // State, PC, IF/ID entry, skid buffer and memory request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      pc_r          <= RESET_PC;
      if_id_valid_r <= 1'b0;
      if_id_inst_r  <= '0;
      if_id_pc_r    <= '0;
      skid_valid_r  <= 1'b0;
      skid_inst_r   <= '0;
      skid_pc_r     <= '0;
      fetch_en_r    <= 1'b0;
      addr_r        <= RESET_PC[ADDR_WIDTH-1:0];
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      if_id_valid_r <= if_id_valid_s;
      if_id_inst_r  <= if_id_inst_s;
      if_id_pc_r    <= if_id_pc_s;
      skid_valid_r  <= skid_valid_s;
      skid_inst_r   <= skid_inst_s;
      skid_pc_r     <= skid_pc_s;
      fetch_en_r    <= fetch_en_s;
      addr_r        <= addr_s;
    end
  end

  assign inst_fetch_enabled = fetch_en_r;
  assign mem_inst_addr      = addr_r;
  assign if_id_valid        = if_id_valid_r;
  assign if_id_inst         = if_id_inst_r;
  assign if_id_pc           = if_id_pc_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit with a response scoreboard.
module tb_instruction_fetch_unit;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy_in;
  logic        inst_fetch_enabled;
  logic [16:0] mem_inst_addr;
  logic        inst_valid;
  logic [31:0] instruction;
  logic        id_ready;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        if_id_valid;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc;

  logic        en2;
  logic [31:0] addr2;
  logic        inst_valid2;
  logic [31:0] instruction2;
  logic        if_id_valid2;
  logic [31:0] if_id_inst2;
  logic [31:0] if_id_pc2;

  int total = 0;
  int bad   = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk                (clk),
    .rst                (rst),
    .rdy_in             (rdy_in),
    .inst_fetch_enabled (inst_fetch_enabled),
    .mem_inst_addr      (mem_inst_addr),
    .inst_valid         (inst_valid),
    .instruction        (instruction),
    .id_ready           (id_ready),
    .branch_taken       (branch_taken),
    .branch_target      (branch_target),
    .if_id_valid        (if_id_valid),
    .if_id_inst         (if_id_inst),
    .if_id_pc           (if_id_pc)
  );

  instruction_fetch_unit #(.ADDR_WIDTH(32), .LEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk                (clk),
    .rst                (rst),
    .rdy_in             (1'b1),
    .inst_fetch_enabled (en2),
    .mem_inst_addr      (addr2),
    .inst_valid         (inst_valid2),
    .instruction        (instruction2),
    .id_ready           (1'b1),
    .branch_taken       (1'b0),
    .branch_target      (32'h0000_0000),
    .if_id_valid        (if_id_valid2),
    .if_id_inst         (if_id_inst2),
    .if_id_pc           (if_id_pc2)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Drive a memory response for the given address and record whether IF/ID should take it
  task automatic respond(input logic [31:0] a, input bit expect_capture);
    exp_t e;
    inst_valid  = 1'b1;
    instruction = inst_of(a);
    if (expect_capture) begin
      e.inst = inst_of(a);
      e.pc   = a;
      sb_q.push_back(e);
    end
  endtask

  task automatic check_ifid(input string tag);
    exp_t e;
    total++;
    assert (sb_q.size() > 0) else begin
      bad++;
      $error("FAIL %s_sb: observed=empty expected=entry", tag);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_valid"}, 64'(if_id_valid), 64'd1);
      chk({tag, "_inst"},  64'(if_id_inst),  64'(e.inst));
      chk({tag, "_pc"},    64'(if_id_pc),    64'(e.pc));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rdy_in = 1'b1; inst_valid = 1'b0; instruction = 32'h0;
    id_ready = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    inst_valid2 = 1'b0; instruction2 = 32'h0;

    // Reset state
    step();
    chk("rst_en",    64'(inst_fetch_enabled), 64'd0);
    chk("rst_valid", 64'(if_id_valid),        64'd0);
    chk("rst_inst",  64'(if_id_inst),         64'd0);
    chk("rst_pc",    64'(if_id_pc),           64'd0);
    chk("rst_addr",  64'(mem_inst_addr),      64'd0);
    rst = 1'b0;
    step();

    // Three back-to-back responses with decode always ready
    id_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("seq_en",   64'(inst_fetch_enabled), 64'd1);
      chk("seq_addr", 64'(mem_inst_addr),      64'(4 * k));
      respond(32'(4 * k), 1'b1);
      step();
      inst_valid = 1'b0;
      check_ifid("seq");
    end
    step();
    chk("drain_valid", 64'(if_id_valid), 64'd0);

    // Back-pressure: second response goes to the skid buffer
    rst = 1'b1;
    #1;
    chk("rst2_en",   64'(inst_fetch_enabled), 64'd0);
    chk("rst2_addr", 64'(mem_inst_addr),      64'd0);
    step();
    rst = 1'b0;
    step();
    id_ready = 1'b0;
    chk("bp_addr0", 64'(mem_inst_addr), 64'h0);
    respond(32'h0, 1'b1);
    step();
    inst_valid = 1'b0;
    check_ifid("bp_first");
    chk("bp_addr4", 64'(mem_inst_addr), 64'h4);
    respond(32'h4, 1'b0);
    step();
    inst_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("full_en", 64'(inst_fetch_enabled), 64'd0);
      chk("full_pc", 64'(if_id_pc),           64'h0);
      if (k < 3) step();
    end
    id_ready = 1'b1;
    sb_q.push_back('{inst: inst_of(32'h4), pc: 32'h4});
    step();
    check_ifid("bp_skid");
    chk("bp_en",   64'(inst_fetch_enabled), 64'd1);
    chk("bp_addr", 64'(mem_inst_addr),      64'h8);

    // Redirect while request 0x8 is outstanding
    branch_taken = 1'b1; branch_target = 32'h103;
    step();
    branch_taken = 1'b0;
    chk("fl_valid", 64'(if_id_valid),   64'd0);
    chk("fl_addr",  64'(mem_inst_addr), 64'h8);
    step();
    chk("fl_hold", 64'(mem_inst_addr), 64'h8);
    respond(32'h8, 1'b0);
    step();
    inst_valid = 1'b0;
    chk("fl_drop_valid", 64'(if_id_valid),        64'd0);
    chk("fl_new_en",     64'(inst_fetch_enabled), 64'd1);
    chk("fl_new_addr",   64'(mem_inst_addr),      64'h100);
    respond(32'h100, 1'b1);
    step();
    inst_valid = 1'b0;
    check_ifid("fl_target");

    // Redirect coincident with a response
    chk("co_addr", 64'(mem_inst_addr), 64'h104);
    respond(32'h104, 1'b0);
    branch_taken = 1'b1; branch_target = 32'h100;
    step();
    inst_valid = 1'b0; branch_taken = 1'b0;
    chk("co_valid", 64'(if_id_valid),   64'd0);
    chk("co_addr2", 64'(mem_inst_addr), 64'h100);
    respond(32'h100, 1'b1);
    step();
    inst_valid = 1'b0;
    check_ifid("co_target");

    // Global stall: every input ignored, nothing moves
    rdy_in = 1'b0;
    inst_valid = 1'b1; instruction = 32'hDEAD_BEEF;
    branch_taken = 1'b1; branch_target = 32'h200; id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("stall_en",    64'(inst_fetch_enabled), 64'd1);
      chk("stall_addr",  64'(mem_inst_addr),      64'h104);
      chk("stall_valid", 64'(if_id_valid),        64'd1);
      chk("stall_pc",    64'(if_id_pc),           64'h100);
    end
    rdy_in = 1'b1; inst_valid = 1'b0; branch_taken = 1'b0;
    step();
    chk("unstall_valid", 64'(if_id_valid),   64'd0);
    chk("unstall_addr",  64'(mem_inst_addr), 64'h104);

    // Reset while in FULL
    id_ready = 1'b0;
    respond(32'h104, 1'b1);
    step();
    inst_valid = 1'b0;
    check_ifid("pre_full");
    respond(32'h108, 1'b0);
    step();
    inst_valid = 1'b0;
    chk("in_full_en", 64'(inst_fetch_enabled), 64'd0);
    rst = 1'b1;
    #1;
    chk("rst_full_valid", 64'(if_id_valid),        64'd0);
    chk("rst_full_inst",  64'(if_id_inst),         64'd0);
    chk("rst_full_pc",    64'(if_id_pc),           64'd0);
    chk("rst_full_en",    64'(inst_fetch_enabled), 64'd0);
    chk("rst_full_addr",  64'(mem_inst_addr),      64'd0);
    step();
    rst = 1'b0; id_ready = 1'b1;
    step();
    chk("post_rst_en",   64'(inst_fetch_enabled), 64'd1);
    chk("post_rst_addr", 64'(mem_inst_addr),      64'd0);

    // PC wrap from 0xFFFFFFFC
    chk("wrap_addr0", 64'(addr2), 64'hFFFF_FFFC);
    chk("wrap_en",    64'(en2),   64'd1);
    inst_valid2 = 1'b1; instruction2 = 32'h1234_5678;
    step();
    inst_valid2 = 1'b0;
    chk("wrap_addr1", 64'(addr2),        64'h0);
    chk("wrap_valid", 64'(if_id_valid2), 64'd1);
    chk("wrap_pc",    64'(if_id_pc2),    64'hFFFF_FFFC);
    chk("wrap_inst",  64'(if_id_inst2),  64'h1234_5678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 17, the memory instruction address width.
REQ-002 SHALL have parameter LEN, default 32, the instruction and PC width.
REQ-003 SHALL have parameter RESET_PC, default 0, the PC value after reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port rdy_in, input, 1 bit: global enable; low freezes all state.
REQ-007 SHALL have port inst_fetch_enabled, output, 1 bit: fetch request level to memory.
REQ-008 SHALL have port mem_inst_addr, output, ADDR_WIDTH bits: request address, PC[ADDR_WIDTH-1:0].
REQ-009 SHALL have port inst_valid, input, 1 bit: one-cycle response strobe from memory.
REQ-010 SHALL have port instruction, input, LEN bits: response data, valid with inst_valid.
REQ-011 SHALL have port id_ready, input, 1 bit: the decode stage accepts the IF/ID entry this cycle.
REQ-012 SHALL have port branch_taken, input, 1 bit: one-cycle PC redirect strobe.
REQ-013 SHALL have port branch_target, input, LEN bits: redirect PC.
REQ-014 SHALL have port if_id_valid, output, 1 bit: the IF/ID entry is valid.
REQ-015 SHALL have port if_id_inst, output, LEN bits: the IF/ID instruction.
REQ-016 SHALL have port if_id_pc, output, LEN bits: the PC of if_id_inst.

Function
REQ-017 SHALL implement an FSM with states IDLE, FETCH, FULL and FLUSH.
REQ-018 SHALL use a request protocol of: inst_fetch_enabled level-high with mem_inst_addr stable until inst_valid, then at most one response per request, returned at least 1 cycle after the request.
REQ-019 SHALL go from IDLE to FETCH unconditionally one cycle after reset release.
REQ-020 SHALL, in FETCH, drive inst_fetch_enabled=1 and mem_inst_addr=PC[ADDR_WIDTH-1:0].
REQ-021 SHALL, in FETCH on inst_valid with the IF/ID slot free or freed this cycle (!if_id_valid or id_ready), register instruction and PC into IF/ID, set if_id_valid=1 next cycle, set PC<=PC+4 and stay in FETCH, giving a next request on the following cycle.
REQ-022 SHALL, in FETCH on inst_valid with the IF/ID slot occupied and id_ready=0, capture instruction and PC into a one-entry skid buffer, set PC<=PC+4 and go to FULL.
REQ-023 SHALL, in FULL, drive inst_fetch_enabled=0, and on id_ready move the skid buffer into IF/ID (if_id_valid stays 1) and go to FETCH.
REQ-024 SHALL, when id_ready=1 with no new entry, clear if_id_valid next cycle.
REQ-025 SHALL, on branch_taken, set PC<=branch_target with bits [1:0] forced to 0, clear if_id_valid, invalidate the skid buffer and ignore id_ready; redirect has priority over all other events.
REQ-026 SHALL, on branch_taken in FETCH with no inst_valid that cycle, go to FLUSH, because a request is outstanding.
REQ-027 SHALL, on branch_taken in FETCH with inst_valid in the same cycle, discard the response and stay in FETCH at the new PC.
REQ-028 SHALL, on branch_taken in FULL or FLUSH, go to FETCH (FLUSH: remain FLUSH if no inst_valid that cycle) with the new PC.
REQ-029 SHALL, in FLUSH, keep inst_fetch_enabled=1 with the old address, discard the next inst_valid, then go to FETCH using the redirected PC.
REQ-030 SHALL compute PC arithmetic modulo 2^LEN, wrapping 32'hFFFFFFFC+4 to 0.
REQ-031 SHALL, while rdy_in=0, hold every register and FSM state and ignore inst_valid, branch_taken and id_ready.

Reset
REQ-032 SHALL, while rst=1, asynchronously force: state=IDLE, PC=RESET_PC, inst_fetch_enabled=0, if_id_valid=0, if_id_inst=0, if_id_pc=0, skid buffer invalid.
REQ-033 SHALL abandon any in-flight request on reset mid-operation; memory is reset by the same rst.

Structure
REQ-034 SHALL place the FSM state encoding (2 bits) and the constant 4 used as the instruction byte stride in the shared defines file.
REQ-035 SHALL be a single module with no sub-modules; the skid buffer is inline registers.

Verification
REQ-036 SHALL verify: reset then 3 responses with id_ready=1 -> addresses 0x0,0x4,0x8; if_id_pc 0x0,0x4,0x8 each 1 cycle after inst_valid.
REQ-037 SHALL verify: id_ready=0 for 5 cycles after the first entry -> second response buffered, enable=0 in FULL; id_ready=1 -> if_id_pc=0x4 then fetch of 0x8.
REQ-038 SHALL verify: branch_taken target 0x103 while request 0x8 is outstanding -> FLUSH, response for 0x8 dropped, next address 0x100, if_id_valid=0 until then.
REQ-039 SHALL verify: branch_taken coincident with inst_valid -> response dropped, next request 0x100 on the following cycle.
REQ-040 SHALL verify: RESET_PC=0xFFFFFFFC -> after the first fetch PC=0, mem_inst_addr=0.
REQ-041 SHALL verify: rst asserted in FULL -> outputs zero immediately; rdy_in=0 for 4 cycles mid-FETCH -> no state change.
